// File: rtl/hit_judge.sv
// Beat-window hit judge: tracks the first press set per metronome beat and updates score,
// combo, lives and game-over. Define HIT_JUDGE_COMBO_BONUS_EN for the combo >= 8 bonus.
module hit_judge #(
  parameter int unsigned                ARROW_BITS  = 2,
  parameter logic [ARROW_BITS:0]        ARROW_NONE  = 3'd4,
  parameter int unsigned                STATE_BITS  = 1,
  parameter logic [STATE_BITS:0]        STATE_RESET = 2'd0,
  parameter logic [STATE_BITS:0]        STATE_GAME  = 2'd1,
  parameter logic [2:0]                 LIVES_INIT  = 3'd5,
  parameter int unsigned                HIT_POINTS  = 10,
  parameter int unsigned                SCORE_MAX   = 9999
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  metronome_clk,
  input  logic [STATE_BITS:0]   state,
  input  logic [ARROW_BITS:0]   arrow3,
  input  logic [3:0]            btn,
  output logic [13:0]           score,
  output logic [7:0]            combo,
  output logic [2:0]            lives,
  output logic                  game_over,
  output logic                  hit_pulse,
  output logic                  miss_pulse
);

  typedef enum logic [1:0] {StArmed, StGood, StBad} win_e;

  logic [2:0]  sync_q;
  logic        beat_q;
  logic [3:0]  btn_prev_q;
  win_e        win_q, win_d, win_merged;
  logic [13:0] score_q, score_d;
  logic [7:0]  combo_q, combo_d;
  logic [2:0]  lives_q, lives_d;
  logic        game_over_q, game_over_d;
  logic        hit_q, hit_d, miss_q, miss_d;

  logic [3:0]  press;
  logic [3:0]  target;
  logic [14:0] bonus;
  logic [14:0] score_sum;

  assign press  = btn & ~btn_prev_q;
  assign target = 4'b0001 << arrow3;

`ifdef HIT_JUDGE_COMBO_BONUS_EN
  assign bonus = (combo_q >= 8'd8) ? 15'd5 : 15'd0;
`else
  assign bonus = 15'd0;
`endif

  assign score_sum = {1'b0, score_q} + 15'(HIT_POINTS) + bonus;

  // First press set of the window decides; later presses are ignored once locked.
  always_comb begin
    win_merged = win_q;
    if (win_q == StArmed && press != 4'b0000) begin
      if (arrow3 == ARROW_NONE || press != target) begin
        win_merged = StBad;
      end else begin
        win_merged = StGood;
      end
    end
  end

  always_comb begin
    win_d       = win_q;
    score_d     = score_q;
    combo_d     = combo_q;
    lives_d     = lives_q;
    game_over_d = game_over_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;

    if (state == STATE_RESET) begin
      win_d       = StArmed;
      score_d     = 14'd0;
      combo_d     = 8'd0;
      lives_d     = LIVES_INIT;
      game_over_d = 1'b0;
    end else if (state != STATE_GAME || game_over_q) begin
      win_d = StArmed;
    end else if (beat_q) begin
      win_d = StArmed;
      case (win_merged)
        StGood:  hit_d  = 1'b1;
        StBad:   miss_d = 1'b1;
        default: miss_d = (arrow3 != ARROW_NONE);
      endcase
      if (hit_d) begin
        score_d = (score_sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : score_sum[13:0];
        combo_d = (combo_q != 8'hFF) ? combo_q + 8'd1 : combo_q;
      end
      if (miss_d) begin
        combo_d     = 8'd0;
        lives_d     = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
        game_over_d = (lives_d == 3'd0);
      end
    end else begin
      win_d = win_merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 3'b000;
      beat_q      <= 1'b0;
      btn_prev_q  <= 4'b0000;
      win_q       <= StArmed;
      score_q     <= 14'd0;
      combo_q     <= 8'd0;
      lives_q     <= LIVES_INIT;
      game_over_q <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      sync_q      <= {metronome_clk, sync_q[2:1]};
      beat_q      <= ~sync_q[0] & sync_q[1];
      btn_prev_q  <= btn;
      win_q       <= win_d;
      score_q     <= score_d;
      combo_q     <= combo_d;
      lives_q     <= lives_d;
      game_over_q <= game_over_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  assign score      = score_q;
  assign combo      = combo_q;
  assign lives      = lives_q;
  assign game_over  = game_over_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;

endmodule

// File: tb/tb_hit_judge.sv
// Scoreboard bench for hit_judge: stimulus pushes expected pulse snapshots, a negedge monitor
// pops and compares whenever a hit or miss pulse appears.
module tb_hit_judge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        metronome_clk;
  logic [1:0]  state;
  logic [2:0]  arrow3;
  logic [3:0]  btn;
  logic [13:0] score;
  logic [7:0]  combo;
  logic [2:0]  lives;
  logic        game_over;
  logic        hit_pulse;
  logic        miss_pulse;

  hit_judge dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .metronome_clk (metronome_clk),
    .state         (state),
    .arrow3        (arrow3),
    .btn           (btn),
    .score         (score),
    .combo         (combo),
    .lives         (lives),
    .game_over     (game_over),
    .hit_pulse     (hit_pulse),
    .miss_pulse    (miss_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hit;
    logic        miss;
    logic [13:0] score;
    logic [7:0]  combo;
    logic [2:0]  lives;
    logic        go;
  } snap_t;

  snap_t q[$];
  int checks = 0;
  int errors = 0;
  int m_score, m_combo, m_lives;
  logic m_go;

  function automatic void model_reset();
    m_score = 0;
    m_combo = 0;
    m_lives = 5;
    m_go    = 1'b0;
  endfunction

  function automatic void push_hit();
    int add = 10;
`ifdef HIT_JUDGE_COMBO_BONUS_EN
    if (m_combo >= 8) add += 5;
`endif
    m_score = (m_score + add > 9999) ? 9999 : m_score + add;
    if (m_combo < 255) m_combo++;
    q.push_back({1'b1, 1'b0, 14'(m_score), 8'(m_combo), 3'(m_lives), m_go});
  endfunction

  function automatic void push_miss();
    m_combo = 0;
    if (m_lives > 0) m_lives--;
    if (m_lives == 0) m_go = 1'b1;
    q.push_back({1'b0, 1'b1, 14'(m_score), 8'(m_combo), 3'(m_lives), m_go});
  endfunction

  always @(negedge clk) begin
    snap_t act;
    snap_t e;
    if (hit_pulse || miss_pulse) begin
      act = {hit_pulse, miss_pulse, score, combo, lives, game_over};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got hit=%0b miss=%0b score=%0d combo=%0d lives=%0d go=%0b",
                 act.hit, act.miss, act.score, act.combo, act.lives, act.go);
      end else begin
        e = q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL judge @%0t: got hit=%0b miss=%0b score=%0d combo=%0d lives=%0d go=%0b, want hit=%0b miss=%0b score=%0d combo=%0d lives=%0d go=%0b",
                   $time, act.hit, act.miss, act.score, act.combo, act.lives, act.go,
                   e.hit, e.miss, e.score, e.combo, e.lives, e.go);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] mask);
    btn = mask;
    tick(1);
    btn = 4'b0000;
    tick(1);
  endtask

  task automatic beat();
    metronome_clk = 1'b1;
    tick(5);
    metronome_clk = 1'b0;
    tick(5);
  endtask

  task automatic check(input string name, input int s, input int c, input int l, input logic g);
    snap_t act;
    snap_t e;
    act = {hit_pulse, miss_pulse, score, combo, lives, game_over};
    e   = {1'b0, 1'b0, 14'(s), 8'(c), 3'(l), g};
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got hit=%0b miss=%0b score=%0d combo=%0d lives=%0d go=%0b, want pulses 0 score=%0d combo=%0d lives=%0d go=%0b",
               name, act.hit, act.miss, act.score, act.combo, act.lives, act.go, s, c, l, g);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; state = 2'd0; arrow3 = 3'd4; btn = 4'b0000; metronome_clk = 1'b0;
    model_reset();
    #12;
    check("async_reset", 0, 0, 5, 1'b0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    state = 2'd1;
    tick(2);

    // Single hit.
    arrow3 = 3'd2; tick(1);
    press(4'b0100); push_hit(); beat();
    // Wrong then right: first press set decides.
    arrow3 = 3'd1;
    press(4'b1000); press(4'b0010); push_miss(); beat();
    // Matching and wrong bit in the same cycle.
    arrow3 = 3'd0;
    press(4'b0011); push_miss(); beat();
    // ARROW_NONE silent window is neutral, a press there is a miss.
    arrow3 = 3'd4;
    beat();
    check("none_silent", 10, 0, 3, 1'b0);
    press(4'b0001); push_miss(); beat();
    // A held button hits once, then yields no press in the next window.
    arrow3 = 3'd3; btn = 4'b1000; tick(1);
    push_hit(); beat();
    push_miss(); beat();
    btn = 4'b0000; tick(1);
    // Non-GAME state holds everything.
    state = 2'd2; arrow3 = 3'd0;
    press(4'b0001); beat();
    check("hold_state", 20, 0, 1, 1'b0);
    state = 2'd1;
    // Silent window with an arrow: last life, game over, then frozen.
    push_miss(); beat();
    press(4'b0001); beat(); beat();
    check("after_game_over", 20, 0, 0, 1'b1);
    state = 2'd0; tick(2);
    check("state_reset", 0, 0, 5, 1'b0);
    model_reset();
    state = 2'd1; tick(1);

    // Press coincident with the beat cycle merges into the closing window.
    arrow3 = 3'd1;
    metronome_clk = 1'b1;
    tick(3);
    btn = 4'b0010; push_hit();
    tick(1);
    btn = 4'b0000;
    tick(4);
    metronome_clk = 1'b0;
    tick(5);

    // Async reset mid-window clears the locked GOOD window.
    press(4'b0010);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("mid_window_reset", 0, 0, 5, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);
    push_miss(); beat();

    state = 2'd0; tick(2);
    model_reset();
    state = 2'd1; tick(1);

    // Long hit streak: combo bonus, combo saturation, score saturation.
    for (int i = 0; i < 1000; i++) begin
      arrow3 = 3'(i % 4);
      press(4'(1 << (i % 4)));
      push_hit();
      beat();
    end
    tick(10);
    check("saturation", m_score, m_combo, m_lives, m_go);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_pulses: got %0d unjudged entries, want 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hit_judge.md
# hit_judge

Downstream consumer of the arrow buffer stage in the DDR game. Watches the target arrow (`arrow3`) and the player's debounced pad buttons across each metronome beat window. Judges every window as hit, miss or neutral, and maintains score, combo, lives and a sticky game-over flag for the display and top-level FSM.

## Interface
Parameters:
- `ARROW_BITS`, 2 — arrow code width minus one; arrow ports are `[ARROW_BITS:0]`
- `ARROW_NONE`, 3'd4 — "no arrow" code; codes 0..3 are UP, DOWN, LEFT, RIGHT
- `STATE_BITS`, 1 — game state width minus one
- `STATE_RESET`, 2'd0 — game state code: reset
- `STATE_GAME`, 2'd1 — game state code: game
- `LIVES_INIT`, 3'd5 — lives loaded on reset
- `HIT_POINTS`, 10 — score added per hit
- `SCORE_MAX`, 9999 — score saturation value

Ports:
- `clk` in 1 — system clock
- `rst_n` in 1 — one clock; reset is asynchronous and active-low
- `metronome_clk` in 1 — beat clock, asynchronous to `clk`, slow
- `state` in `[STATE_BITS:0]` — top-level game state
- `arrow3` in `[ARROW_BITS:0]` — arrow currently in the hit zone
- `btn` in 4 — debounced pad levels; bit i = arrow code i
- `score` out 14 — running score, saturating at `SCORE_MAX`
- `combo` out 8 — consecutive hits, saturating at 255
- `lives` out 3 — remaining lives
- `game_over` out 1 — sticky, set when lives reach 0
- `hit_pulse` out 1 — one-cycle pulse on a judged hit
- `miss_pulse` out 1 — one-cycle pulse on a judged miss

## Operation
- Beat detect: 3-bit shift synchronizer `{metronome_clk, s[2:1]}`. `beat` is registered as `~s[0] & s[1]`, so it is cycle-aligned with the arrow buffer's shift enable.
- Button edges: `btn_prev` register; `press = btn & ~btn_prev`. A held button produces no new press.
- Window FSM, one per beat, with states:
  - `ARMED` (initial)
  - `GOOD`: the first press set was exactly bit `arrow3`, and `arrow3 != ARROW_NONE`
  - `BAD`: the first press set contained any other bit, or any press occurred while `arrow3 == ARROW_NONE`
- `GOOD` and `BAD` are locked until the window closes. Later presses are ignored.
- A press in the same cycle as both the matching bit and a wrong bit → `BAD`.
- Window close happens on the `beat` cycle. `arrow3` still holds the closing window's arrow in that cycle. A press in the beat cycle is merged into the closing window before judging.
- Judgement at close:
  - `GOOD` → hit: `score += HIT_POINTS` (+bonus, see Configuration), saturating; `combo += 1`, saturating; `hit_pulse = 1`.
  - `BAD`, or `ARMED` with `arrow3 != ARROW_NONE` → miss: `combo = 0`; `lives -= 1`, not below 0; `miss_pulse = 1`. If `lives` becomes 0, `game_over = 1` in the same cycle.
  - `ARMED` with `ARROW_NONE` → neutral: no change.
  - The FSM returns to `ARMED` after every close.
- `state == STATE_RESET`: synchronously load score 0, combo 0, lives `LIVES_INIT`, game_over 0, FSM `ARMED`, pulses 0.
- Any other non-GAME state, or `game_over == 1`: hold all counters and ignore beats and presses. The FSM is forced to `ARMED`. Synchronizers keep running.
- Score arithmetic is done at 15 bits, then clamped to `SCORE_MAX`.

## Timing
- Async reset values: score 0, combo 0, lives `LIVES_INIT`, game_over 0, pulses 0, synchronizer 0, `btn_prev` 0, FSM `ARMED`.
- Beat latency: `metronome_clk` rise → `beat` after 3 `clk`. Outputs update 1 cycle after `beat`; `hit_pulse`/`miss_pulse` are high for exactly that cycle.
- Press latency: a `btn` rise is reflected in the FSM 1 cycle later.
- `rst_n` deassert mid-window: the first window after reset is judged like any other. `arrow3` is `ARROW_NONE` after reset, so it is neutral unless pressed.
- All outputs are registered; there are no combinational paths from inputs.

## Configuration
- `HIT_JUDGE_COMBO_BONUS_EN` defined: a hit adds 5 extra points when `combo >= 8`, using the pre-increment value.
- `HIT_JUDGE_COMBO_BONUS_EN` undefined: every hit adds exactly `HIT_POINTS`. Combo is still counted and output.

## Test plan
- Single hit: GAME, arrow3=2, press `btn=4'b0100` mid-window, then beat → score 10, combo 1, one `hit_pulse`.
- Wrong then right: arrow3=1, press bit 3, then bit 1 → miss; lives 5→4; combo 0; score unchanged.
- Silent window: arrow3=0, no press → miss. Five such beats → lives 0, `game_over` 1, further beats change nothing. `STATE_RESET` restores lives 5 and game_over 0.
- ARROW_NONE: no press → no pulses. A press → miss, lives decremented.
- Combo bonus (macro on): 9 consecutive hits → score 95 (8×10 + 15); macro off → 90. Score preset near 9995 plus one hit → 9999.
- Beat-cycle press plus async `rst_n` pulse mid-window: a press coincident with `beat` counts as a hit; after reset, all outputs are at reset values in the next cycle.
